// File: rtl/merge_out_packer.sv
// Packs P-record beats from the merger output FIFO into memory-width lines,
// tags each line with its byte address, and pads the final partial line with
// all-ones sentinel records. A fill register feeds an output register so a
// new line can be assembled while the previous one waits on the write channel.
module merge_out_packer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned P          = 8,
  parameter int unsigned LINE_WIDTH = 512,
  parameter int unsigned ADDR_WIDTH = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [ADDR_WIDTH-1:0]   i_base_addr,
  input  logic [31:0]             i_num_beats,
  input  logic [P*DATA_WIDTH-1:0] i_data,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic [LINE_WIDTH-1:0]   o_line,
  output logic                    o_line_valid,
  output logic [ADDR_WIDTH-1:0]   o_addr,
  input  logic                    i_line_ready,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int unsigned BeatW = P * DATA_WIDTH;
  localparam int unsigned BEATS = LINE_WIDTH / BeatW;
  localparam int unsigned SlotW = $clog2(BEATS + 1);
  localparam logic [ADDR_WIDTH-1:0] LineBytes = ADDR_WIDTH'(LINE_WIDTH / 8);
  localparam logic [SlotW-1:0]      LastSlot  = SlotW'(BEATS - 1);

  typedef enum logic [1:0] {StIdle, StFill, StFlush, StDone} state_e;

  state_e                  state_q, state_d;
  logic [31:0]             rem_q, rem_d;
  logic [SlotW-1:0]        slot_q, slot_d;
  logic [LINE_WIDTH-1:0]   fill_q, fill_d;
  logic                    full_q, full_d;
  logic [LINE_WIDTH-1:0]   out_line_q, out_line_d;
  logic                    out_valid_q, out_valid_d;
  logic [ADDR_WIDTH-1:0]   out_addr_q, out_addr_d;
  logic [ADDR_WIDTH-1:0]   next_addr_q, next_addr_d;

  logic                    out_free;
  logic                    ready;
  logic                    accept;
  logic                    last_beat;
  logic [LINE_WIDTH-1:0]   merged;
  logic [LINE_WIDTH-1:0]   restart;

  // Slots at or above cnt were never written in this line; fill them with sentinels.
  function automatic logic [LINE_WIDTH-1:0] pad_line(input logic [LINE_WIDTH-1:0] line,
                                                     input logic [SlotW-1:0]      cnt);
    logic [LINE_WIDTH-1:0] res;
    res = line;
    for (int s = 0; s < int'(BEATS); s++) begin
      if (SlotW'(s) >= cnt) res[s*BeatW +: BeatW] = '1;
    end
    return res;
  endfunction

  // Handshake terms and the candidate line images built from the incoming beat.
  always_comb begin
    out_free  = !out_valid_q || i_line_ready;
    ready     = (state_q == StFill) && (rem_q != '0) && (!full_q || out_free);
    accept    = i_valid && ready;
    last_beat = (rem_q == 32'd1);
    merged    = fill_q;
    for (int s = 0; s < int'(BEATS); s++) begin
      if (SlotW'(s) == slot_q) merged[s*BeatW +: BeatW] = i_data;
    end
    // Beat landing in slot 0 of a fill register that is being emptied this cycle.
    restart = fill_q;
    restart[BeatW-1:0] = i_data;
  end

  // Datapath and FSM next-state.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    slot_d      = slot_q;
    fill_d      = fill_q;
    full_d      = full_q;
    out_line_d  = out_line_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    next_addr_d = next_addr_q;

    if (out_valid_q && i_line_ready) out_valid_d = 1'b0;

    if (full_q) begin
      // Completed line waiting; it moves as soon as the output register frees up.
      if (out_free) begin
        out_line_d  = fill_q;
        out_valid_d = 1'b1;
        out_addr_d  = next_addr_q;
        next_addr_d = next_addr_q + LineBytes;
        slot_d      = '0;
        full_d      = 1'b0;
        if (accept) begin
          rem_d  = rem_q - 32'd1;
          slot_d = SlotW'(1);
          fill_d = restart;
          if ((BEATS == 1) || last_beat) begin
            fill_d = pad_line(restart, SlotW'(1));
            full_d = 1'b1;
          end
        end
      end
    end else if (accept) begin
      rem_d = rem_q - 32'd1;
      if ((slot_q == LastSlot) || last_beat) begin
        if (out_free) begin
          // Bypass straight to the output so the line appears one cycle later.
          out_line_d  = pad_line(merged, slot_q + SlotW'(1));
          out_valid_d = 1'b1;
          out_addr_d  = next_addr_q;
          next_addr_d = next_addr_q + LineBytes;
          slot_d      = '0;
        end else begin
          fill_d = pad_line(merged, slot_q + SlotW'(1));
          full_d = 1'b1;
          slot_d = slot_q + SlotW'(1);
        end
      end else begin
        fill_d = merged;
        slot_d = slot_q + SlotW'(1);
      end
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (i_start) begin
          rem_d       = i_num_beats;
          next_addr_d = i_base_addr;
          slot_d      = '0;
          full_d      = 1'b0;
          state_d     = (i_num_beats == '0) ? StFlush : StFill;
        end
      end
      StFill: begin
        if (accept && last_beat) state_d = StFlush;
      end
      StFlush: begin
        // Nothing left in the fill register and the output empties this cycle.
        if (!full_q && out_free) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset that also discards any partial line.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      slot_q      <= '0;
      fill_q      <= '0;
      full_q      <= 1'b0;
      out_line_q  <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      next_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      slot_q      <= slot_d;
      fill_q      <= fill_d;
      full_q      <= full_d;
      out_line_q  <= out_line_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      next_addr_q <= next_addr_d;
    end
  end

  // Output mapping.
  always_comb begin
    o_ready      = ready;
    o_line       = out_line_q;
    o_line_valid = out_valid_q;
    o_addr       = out_addr_q;
    o_busy       = (state_q == StFill) || (state_q == StFlush);
    o_done       = (state_q == StDone);
  end

endmodule
